uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, the counterpart of the team's UART_TX path.
- Oversamples the serial line RX_IN at PRESCALE x baud and checks the start bit for glitches.
- Recovers LSB-first data, optionally checks parity, checks the stop bit.
- Presents each frame on a parallel bus with a one-cycle valid strobe or a one-cycle error strobe. Sits between the pad/line input and the system register file / FIFO.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
CLK  input  1  oversampling clock (PRESCALE x baud)
RST  input  1  asynchronous, active-low reset
RX_IN  input  1  serial line, idle high, asynchronous to CLK
PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present after data
PAR_TYP  input  1  0 = even, 1 = odd parity
P_DATA  output  DATA_WIDTH  received data word, registered
DATA_VALID  output  1  one-cycle pulse: P_DATA holds a good frame
PAR_ERR  output  1  one-cycle pulse: parity mismatch
STP_ERR  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (RST low, asynchronous):
  - FSM enters IDLE.
  - Synchronizer flops are set to 1.
  - All counters are cleared.
  - P_DATA = 0, DATA_VALID = PAR_ERR = STP_ERR = 0.
  - Reset mid-frame abandons the frame with no strobe.
- Input synchronization: RX_IN passes through a 2-FF synchronizer (rx_s). All logic uses rx_s only, so there are 2 cycles of input latency.
- Counters:
  - edge_cnt runs 0..P-1 within each bit, where P is the latched PRESCALE.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Configuration latch: PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition and held for the whole frame. Changes mid-frame have no effect. A PRESCALE value other than 8, 16 or 32 is treated as 8.
- Sampling:
  - rx_s is captured at edge_cnt = P/2-2, P/2-1 and P/2.
  - The bit value is the majority of those 3 samples, evaluated at edge_cnt = P-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0, go to START. That cycle counts as edge_cnt = 0 of the start bit.
  - START: at edge_cnt = P-1, majority 0 -> DATA with bit_cnt = 0; majority 1 (glitch) -> IDLE with no strobe.
  - DATA: at edge_cnt = P-1, shift the majority bit into a shift register, LSB first. After bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: at edge_cnt = P-1, store the parity bit. Expected parity is XOR(data) for even, ~XOR(data) for odd.
  - STOP: at edge_cnt = P-1, evaluate the frame and go to IDLE.
- Frame result, registered so it appears the cycle after STOP edge_cnt = P-1:
  - Stop bit = 1 and no parity error: P_DATA <= shift register, DATA_VALID = 1 for one cycle.
  - Parity error: PAR_ERR = 1, DATA_VALID = 0, P_DATA unchanged.
  - Stop bit = 0: STP_ERR = 1, DATA_VALID = 0, P_DATA unchanged.
  - Both errors in one frame: PAR_ERR and STP_ERR pulse together.
- Back-to-back frames: IDLE accepts a start bit on the cycle immediately after STOP, so there are no dead cycles. Continuous frames at exactly 1 baud are received without slip.
- Latency: DATA_VALID rises (1 + DATA_WIDTH + PAR_EN + 1) x P + 2 cycles after the RX_IN falling edge, ±1 for synchronizer phase.
- Outputs are strobes only: there is no handshake or back-pressure. The consumer must capture P_DATA on DATA_VALID. P_DATA holds its value until the next good frame.

Test Plan:
- P=8, PAR_EN=0: send 0xA5 with stop=1 -> single DATA_VALID pulse, P_DATA=0xA5, PAR_ERR=STP_ERR=0, pulse ~82 cycles after the falling edge.
- P=16, PAR_EN=1, PAR_TYP=0: send 0x3C with parity 0, then 0x3C with parity 1 -> first frame gives DATA_VALID with 0x3C; second gives PAR_ERR pulse, no DATA_VALID, P_DATA stays 0x3C.
- P=32, PAR_TYP=1: send 0x81 with stop bit forced 0 -> STP_ERR pulse only; P_DATA retains its previous value.
- Start glitch: RX_IN low for 3 cycles at P=16, then high -> FSM returns to IDLE, no strobe. A following valid frame 0x55 is received correctly.
- Back-to-back: 4 frames 0x00, 0xFF, 0x12, 0xED at P=8 with no idle gap -> 4 DATA_VALID pulses exactly 80 cycles apart, correct data.
- Reset mid-DATA (RST low for 2 cycles at bit 4 of 0x96) -> all outputs 0, no strobe. Next frame 0x69 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input sync, PRESCALE-x oversampling with 3-sample majority vote,
// LSB-first data, optional parity, stop check; results presented as one-cycle strobes.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rx_s_q;
  logic [5:0]            p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic [5:0] half;
  logic       last_edge;
  logic       maj;
  logic       perr;
  logic       serr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      p_q          <= 6'd8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= '1;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      sync1_q      <= RX_IN;
      rx_s_q       <= sync1_q;
      state_q      <= state_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    half      = p_q >> 1;
    last_edge = (edge_cnt_q == p_q - 6'd1);
    maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    perr      = par_en_q & (par_bit_q != ((^shift_q) ^ par_typ_q));
    serr      = ~maj;

    if (state_q != IDLE) begin
      if (edge_cnt_q == half - 6'd2) smp_d[0] = rx_s_q;
      if (edge_cnt_q == half - 6'd1) smp_d[1] = rx_s_q;
      if (edge_cnt_q == half)        smp_d[2] = rx_s_q;
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + 6'd1;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s_q) begin
          // The detecting cycle is edge 0 of the start bit, so counting resumes at 1.
          state_d    = START;
          edge_cnt_d = 6'd1;
          p_d        = (PRESCALE == 6'd16 || PRESCALE == 6'd32) ? PRESCALE : 6'd8;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      START: begin
        if (last_edge) begin
          state_d   = maj ? IDLE : DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (last_edge) begin
          shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          par_bit_d = maj;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          par_err_d = perr;
          stp_err_d = serr;
          if (!perr && !serr) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected strobes are queued as frames are driven
// and checked when the receiver raises DATA_VALID, PAR_ERR or STP_ERR.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] flags;  // {valid, par_err, stp_err}
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         strobe_cyc[$];
  int         cyc = 0;
  int         n_strobe = 0;
  int         total = 0;
  int         bad = 0;
  int         fall_cyc = 0;
  logic [7:0] good_data = 8'h00;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b1 && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      exp_t e;
      n_strobe++;
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("flags", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, {29'd0, e.flags});
        chk("p_data", {24'd0, P_DATA}, {24'd0, e.data});
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic par_flip, input logic stop_bit);
    logic pb, perr, serr, valid;
    exp_t e;
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    pb    = (^d) ^ ptyp ^ par_flip;
    perr  = pen & par_flip;
    serr  = ~stop_bit;
    valid = ~perr & ~serr;
    if (valid) good_data = d;
    e.flags = {valid, perr, serr};
    e.data  = good_data;
    sb.push_back(e);
    fall_cyc = cyc;
    RX_IN = 1'b0;
    tick(p);
    // Scramble config after the start bit: the receiver must use the latched values.
    PRESCALE = (p == 8) ? 6'd32 : 6'd8;
    PAR_EN   = ~pen;
    PAR_TYP  = ~ptyp;
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      tick(p);
    end
    if (pen) begin
      RX_IN = pb;
      tick(p);
    end
    RX_IN = stop_bit;
    tick(p);
    RX_IN = 1'b1;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_strobe < target; i++) tick(1);
    chk(tag, n_strobe, target);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pdata"}, {24'd0, P_DATA}, 32'd0);
    chk({tag, "_strobes"}, {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    logic [7:0] d96;
    logic [7:0] b2b [4];

    RST = 1'b0;
    tick(3);
    chk_outputs_zero("in_reset");
    RST = 1'b1;
    tick(3);
    chk_outputs_zero("after_reset");

    // P=8, no parity, 0xA5, latency check
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_strobes(1, 20, "a5_strobe");
    lat = strobe_cyc[strobe_cyc.size()-1] - fall_cyc;
    chk("lat_p8", (lat >= 81 && lat <= 83) ? 82 : lat, 82);
    tick(8);

    // P=16 even parity: good frame, then parity error
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_strobes(2, 20, "3c_good_strobe");
    tick(16);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_strobes(3, 20, "3c_par_strobe");
    tick(2);
    chk("hold_after_par", {24'd0, P_DATA}, 32'h3C);
    tick(16);

    // P=32 odd parity, stop bit forced low
    send_frame(8'h81, 32, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_strobes(4, 20, "81_stp_strobe");
    tick(100);
    chk("hold_after_stp", {24'd0, P_DATA}, 32'h3C);
    chk("stp_no_extra", n_strobe, 4);

    // Start glitch at P=16, then a valid frame
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(40);
    chk("glitch_no_strobe", n_strobe, 4);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_strobes(5, 20, "55_strobe");
    tick(10);

    // Back-to-back at P=8, no idle gap
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h12; b2b[3] = 8'hED;
    base = strobe_cyc.size();
    for (int k = 0; k < 4; k++) send_frame(b2b[k], 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_strobes(9, 20, "b2b_strobes");
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b_gap%0d", k), strobe_cyc[base+k] - strobe_cyc[base+k-1], 80);
    tick(10);

    // Reset in the middle of bit 4 of 0x96
    d96 = 8'h96;
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d96[i];
      tick(16);
    end
    RX_IN = d96[4];
    tick(8);
    RST = 1'b0;
    tick(2);
    chk_outputs_zero("mid_reset");
    RX_IN = 1'b1;
    RST   = 1'b1;
    good_data = 8'h00;
    tick(200);
    chk("reset_no_strobe", n_strobe, 9);
    chk_outputs_zero("post_reset");
    send_frame(8'h69, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_strobes(10, 20, "69_strobe");
    tick(20);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
